ctx_resp: RTL and testbench

- Responder end of the CTX byte-stream interface: consumes the `val`/`in[7:0]` stream and produces `out[7:0]`.
- Parses framed commands of one header byte plus N data bytes, runs a per-command reduction, and presents the result on `out` with a one-cycle `out_val` strobe.
- This is the DUT-side block that the CTX driver stimulates and the CTX monitor observes.

---
 rtl/ctx_resp.sv | 139 +++++++++++++
 tb/tb_ctx_resp.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ctx_resp.sv
// CTX byte-stream responder: parses header + N data bytes, reduces them (SUM/XOR/MAX/ECHO).
// Optional mid-command idle abort is enabled by defining CTX_RESP_TIMEOUT_EN.
module ctx_resp #(
   parameter int MAX_LEN = 63,
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       val,
   input  logic [7:0] in,
   output logic [7:0] out,
   output logic       out_val,
   output logic       busy
);

   if (MAX_LEN < 1 || MAX_LEN > 63) begin : g_bad_max_len
      $error("ctx_resp: MAX_LEN must be in 1..63");
   end
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("ctx_resp: TIMEOUT must be in 1..255");
   end

   typedef enum logic {IDLE, DATA} state_t;

   localparam logic [1:0] OP_SUM  = 2'b00;
   localparam logic [1:0] OP_XOR  = 2'b01;
   localparam logic [1:0] OP_MAX  = 2'b10;
   localparam logic [1:0] OP_ECHO = 2'b11;

   state_t     state_q, state_d;
   logic [1:0] op_q, op_d;
   logic [5:0] cnt_q, cnt_d;
   logic [7:0] acc_q, acc_d;
   logic [7:0] out_q, out_d;
   logic       out_val_q, out_val_d;
   logic [7:0] acc_next;

`ifdef CTX_RESP_TIMEOUT_EN
   logic [7:0] gap_q, gap_d;
`endif

   always_comb begin
      acc_next = acc_q;
      unique case (op_q)
         OP_SUM:  acc_next = acc_q + in;
         OP_XOR:  acc_next = acc_q ^ in;
         OP_MAX:  acc_next = (in > acc_q) ? in : acc_q;
         default: acc_next = acc_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      out_d     = out_q;
      out_val_d = 1'b0;
`ifdef CTX_RESP_TIMEOUT_EN
      gap_d     = 8'h00;
`endif
      unique case (state_q)
         IDLE: begin
            if (val) begin
               op_d  = in[7:6];
               cnt_d = in[5:0];
               acc_d = 8'h00;
               if (in[5:0] == 6'd0) begin
                  // Zero-length ECHO has nothing to pass through, so it is silent.
                  if (in[7:6] != OP_ECHO) begin
                     out_d     = 8'h00;
                     out_val_d = 1'b1;
                  end
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (val) begin
               acc_d = acc_next;
               cnt_d = cnt_q - 6'd1;
               if (op_q == OP_ECHO) begin
                  out_d     = in;
                  out_val_d = 1'b1;
               end
               if (cnt_q == 6'd1) begin
                  state_d = IDLE;
                  if (op_q != OP_ECHO) begin
                     out_d     = acc_next;
                     out_val_d = 1'b1;
                  end
               end
            end
`ifdef CTX_RESP_TIMEOUT_EN
            else if (gap_q == 8'(TIMEOUT - 1)) begin
               state_d   = IDLE;
               acc_d     = 8'h00;
               cnt_d     = 6'd0;
               out_d     = 8'hEE;
               out_val_d = 1'b1;
            end else begin
               gap_d = gap_q + 8'd1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         op_q      <= OP_SUM;
         cnt_q     <= 6'd0;
         acc_q     <= 8'h00;
         out_q     <= 8'h00;
         out_val_q <= 1'b0;
`ifdef CTX_RESP_TIMEOUT_EN
         gap_q     <= 8'h00;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         out_q     <= out_d;
         out_val_q <= out_val_d;
`ifdef CTX_RESP_TIMEOUT_EN
         gap_q     <= gap_d;
`endif
      end
   end

   assign out     = out_q;
   assign out_val = out_val_q;
   assign busy    = (state_q == DATA);

endmodule

// File: tb/tb_ctx_resp.sv
// Directed bench for ctx_resp: reset, each opcode, gaps, len=0, back-to-back, mid-command reset.
module tb_ctx_resp;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       val = 1'b0;
   logic [7:0] in = 8'h00;
   logic [7:0] out;
   logic       out_val;
   logic       busy;

   int checks = 0;
   int errors = 0;

   ctx_resp #(.MAX_LEN(63), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .val(val), .in(in),
      .out(out), .out_val(out_val), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one input cycle, then land 1 time unit after the consuming edge.
   task automatic cyc(input logic v, input logic [7:0] b);
      val = v;
      in  = b;
      @(posedge clk);
      #1;
   endtask

   task automatic expect3(input string tag, input logic [7:0] o, input logic ov, input logic bz);
      chk({tag, ".out"}, out, o);
      chk({tag, ".out_val"}, {7'd0, out_val}, {7'd0, ov});
      chk({tag, ".busy"}, {7'd0, busy}, {7'd0, bz});
   endtask

   task automatic expect2(input string tag, input logic ov, input logic bz);
      chk({tag, ".out_val"}, {7'd0, out_val}, {7'd0, ov});
      chk({tag, ".busy"}, {7'd0, busy}, {7'd0, bz});
   endtask

   initial begin
      // Reset held with junk on the bus.
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 8'hFF);
         expect3("reset", 8'h00, 1'b0, 1'b0);
      end
      rst_n = 1'b1;

      // SUM with wrap: 80+90+05 = 0x115 -> 0x15.
      cyc(1'b1, 8'h03); expect2("sum.hdr", 1'b0, 1'b1);
      cyc(1'b1, 8'h80); expect2("sum.d0", 1'b0, 1'b1);
      cyc(1'b1, 8'h90); expect2("sum.d1", 1'b0, 1'b1);
      cyc(1'b1, 8'h05); expect3("sum.res", 8'h15, 1'b1, 1'b0);
      cyc(1'b0, 8'h00); expect3("sum.hold", 8'h15, 1'b0, 1'b0);

      // XOR with a two-cycle gap: A5 ^ 5A = FF.
      cyc(1'b1, 8'h42); expect2("xor.hdr", 1'b0, 1'b1);
      cyc(1'b1, 8'hA5); expect2("xor.d0", 1'b0, 1'b1);
      cyc(1'b0, 8'h33); expect2("xor.gap0", 1'b0, 1'b1);
      cyc(1'b0, 8'h44); expect2("xor.gap1", 1'b0, 1'b1);
      cyc(1'b1, 8'h5A); expect3("xor.res", 8'hFF, 1'b1, 1'b0);

      // MAX, unsigned: max(7F, 80) = 80.
      cyc(1'b1, 8'h82); expect2("max.hdr", 1'b0, 1'b1);
      cyc(1'b1, 8'h7F); expect2("max.d0", 1'b0, 1'b1);
      cyc(1'b1, 8'h80); expect3("max.res", 8'h80, 1'b1, 1'b0);

      // ECHO of two bytes.
      cyc(1'b1, 8'hC2); expect3("echo.hdr", 8'h80, 1'b0, 1'b1);
      cyc(1'b1, 8'h11); expect3("echo.b0", 8'h11, 1'b1, 1'b1);
      cyc(1'b1, 8'h22); expect3("echo.b1", 8'h22, 1'b1, 1'b0);

      // len=0 SUM emits 00; len=0 ECHO is silent.
      cyc(1'b0, 8'h00); expect3("len0.pre", 8'h22, 1'b0, 1'b0);
      cyc(1'b1, 8'h00); expect3("len0.sum", 8'h00, 1'b1, 1'b0);
      cyc(1'b1, 8'hC0); expect3("len0.echo", 8'h00, 1'b0, 1'b0);

      // Back-to-back commands: second header lands on the first's out_val cycle.
      cyc(1'b1, 8'h01); expect2("b2b.hdr0", 1'b0, 1'b1);
      cyc(1'b1, 8'h07); expect3("b2b.res0", 8'h07, 1'b1, 1'b0);
      cyc(1'b1, 8'h01); expect3("b2b.hdr1", 8'h07, 1'b0, 1'b1);
      cyc(1'b1, 8'h09); expect3("b2b.res1", 8'h09, 1'b1, 1'b0);

      // Reset mid-command abandons it.
      cyc(1'b1, 8'h05); expect2("rst.hdr", 1'b0, 1'b1);
      cyc(1'b1, 8'h10); expect2("rst.d0", 1'b0, 1'b1);
      cyc(1'b1, 8'h20); expect2("rst.d1", 1'b0, 1'b1);
      rst_n = 1'b0;
      cyc(1'b0, 8'h00); expect3("rst.mid", 8'h00, 1'b0, 1'b0);
      rst_n = 1'b1;
      cyc(1'b0, 8'h00); expect3("rst.after", 8'h00, 1'b0, 1'b0);
      cyc(1'b1, 8'h41); expect2("rst.newhdr", 1'b0, 1'b1);
      cyc(1'b1, 8'h3C); expect3("rst.newres", 8'h3C, 1'b1, 1'b0);

`ifdef CTX_RESP_TIMEOUT_EN
      // 16 idle cycles mid-command abort with EE.
      cyc(1'b1, 8'h04); cyc(1'b1, 8'h01);
      for (int i = 0; i < 15; i++) begin
         cyc(1'b0, 8'h00); expect2("to.wait", 1'b0, 1'b1);
      end
      cyc(1'b0, 8'h00); expect3("to.abort", 8'hEE, 1'b1, 1'b0);
      // 15 idle cycles do not abort: 01+02+03+04 = 0A.
      cyc(1'b1, 8'h04); cyc(1'b1, 8'h01);
      for (int i = 0; i < 15; i++) begin
         cyc(1'b0, 8'h00); expect2("to.short", 1'b0, 1'b1);
      end
      cyc(1'b1, 8'h02); expect2("to.d1", 1'b0, 1'b1);
      cyc(1'b1, 8'h03); expect2("to.d2", 1'b0, 1'b1);
      cyc(1'b1, 8'h04); expect3("to.res", 8'h0A, 1'b1, 1'b0);
`else
      // Without the timeout, a long gap just waits: 10+20 = 30.
      cyc(1'b1, 8'h02); cyc(1'b1, 8'h10);
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 8'h00); expect2("nto.wait", 1'b0, 1'b1);
      end
      cyc(1'b1, 8'h20); expect3("nto.res", 8'h30, 1'b1, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
